// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two byte-enabled write ports,
// optional write-to-read bypass and a one-entry-per-cycle hardware clear sweep.
//
// state    | meaning
// ST_IDLE  | normal operation, writes accepted and bypassed
// ST_CLEAR | sweep zeroes entry[r_clr_cnt] each edge, writes ignored
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic                     i_wr0_en,
  input  logic [ADDR_W-1:0]        i_wr0_addr,
  input  logic [DATA_W-1:0]        i_wr0_data,
  input  logic [DATA_W/8-1:0]      i_wr0_be,
  input  logic                     i_wr1_en,
  input  logic [ADDR_W-1:0]        i_wr1_addr,
  input  logic [DATA_W-1:0]        i_wr1_data,
  input  logic [DATA_W/8-1:0]      i_wr1_be,
  input  logic                     i_clr_start,
  output logic                     o_clr_busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_wr0_ok;
  logic                w_wr1_ok;

  // Writes to r0 are dropped here so storage and bypass share one qualifier.
  assign w_wr0_ok = i_wr0_en && (r_state == ST_IDLE) && !((ZERO_REG != 0) && (i_wr0_addr == '0));
  assign w_wr1_ok = i_wr1_en && (r_state == ST_IDLE) && !((ZERO_REG != 0) && (i_wr1_addr == '0));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clr_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_clr_start) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_cnt_nxt;
    end
  end

  assign o_clr_busy = (r_state == ST_CLEAR);

  // wr1 byte updates come after wr0 so the later assignment wins on collisions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (w_wr0_ok && i_wr0_be[b]) r_mem[i_wr0_addr][8*b +: 8] <= i_wr0_data[8*b +: 8];
        if (w_wr1_ok && i_wr1_be[b]) r_mem[i_wr1_addr][8*b +: 8] <= i_wr1_data[8*b +: 8];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_word;

    assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_word = r_mem[w_addr];
      if ((BYPASS != 0) && (r_state == ST_IDLE)) begin
        for (int b = 0; b < NB; b++) begin
          if (w_wr0_ok && (i_wr0_addr == w_addr) && i_wr0_be[b]) w_word[8*b +: 8] = i_wr0_data[8*b +: 8];
          if (w_wr1_ok && (i_wr1_addr == w_addr) && i_wr1_be[b]) w_word[8*b +: 8] = i_wr1_data[8*b +: 8];
        end
      end
      if ((ZERO_REG != 0) && (w_addr == '0)) w_word = '0;
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = w_word;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: instance a uses defaults (ZERO_REG=1, BYPASS=1), instance b
// uses ZERO_REG=0, BYPASS=0; both are compared each cycle with an array-based reference.
module tb_reg_file_mp;
  localparam int DW  = 32;
  localparam int DEP = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data_a, rd_data_b;
  logic              wr0_en, wr1_en;
  logic [AW-1:0]     wr0_addr, wr1_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [DW/8-1:0]   wr0_be, wr1_be;
  logic              clr_start;
  logic              busy_a, busy_b;

  reg_file_mp #(.DATA_W(DW), .DEPTH(DEP), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_a),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data), .i_wr0_be(wr0_be),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data), .i_wr1_be(wr1_be),
    .i_clr_start(clr_start), .o_clr_busy(busy_a));

  reg_file_mp #(.DATA_W(DW), .DEPTH(DEP), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data), .i_wr0_be(wr0_be),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data), .i_wr1_be(wr1_be),
    .i_clr_start(clr_start), .o_clr_busy(busy_b));

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [DW-1:0] mem [2][DEP];
  bit          m_busy;
  int          m_idx;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] overlay(input logic [DW-1:0] v, input logic [DW-1:0] d,
                                            input logic [DW/8-1:0] be);
    for (int b = 0; b < DW/8; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  // which=0: zero register plus bypass; which=1: neither
  function automatic logic [DW-1:0] exp_rd(input int which, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (which == 0 && a == 0) return '0;
    v = mem[which][a];
    if (which == 0 && !m_busy) begin
      if (wr0_en && wr0_addr == a) v = overlay(v, wr0_data, wr0_be);
      if (wr1_en && wr1_addr == a) v = overlay(v, wr1_data, wr1_be);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) begin mem[0][i] = '0; mem[1][i] = '0; end
    m_busy = 0;
    m_idx  = 0;
  endtask

  task automatic model_edge();
    if (m_busy) begin
      mem[0][m_idx] = '0;
      mem[1][m_idx] = '0;
      m_idx++;
      if (m_idx == DEP) m_busy = 0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (wr0_en && !(w == 0 && wr0_addr == 0)) mem[w][wr0_addr] = overlay(mem[w][wr0_addr], wr0_data, wr0_be);
        if (wr1_en && !(w == 0 && wr1_addr == 0)) mem[w][wr1_addr] = overlay(mem[w][wr1_addr], wr1_data, wr1_be);
      end
      if (clr_start) begin m_busy = 1; m_idx = 0; end
    end
  endtask

  task automatic idle_inputs();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0; wr0_be = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0; wr1_be = '0;
    clr_start = 0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic check_reads(input string tag);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s_a%0d", tag, k), rd_data_a[k*DW +: DW], exp_rd(0, rd_addr[k*AW +: AW]));
      chk($sformatf("%s_b%0d", tag, k), rd_data_b[k*DW +: DW], exp_rd(1, rd_addr[k*AW +: AW]));
    end
    chk($sformatf("%s_busy_a", tag), {31'b0, busy_a}, {31'b0, m_busy});
    chk($sformatf("%s_busy_b", tag), {31'b0, busy_b}, {31'b0, m_busy});
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  task automatic cyc(input string tag);
    @(negedge clk);
    check_reads(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    idle_inputs();
    set_rd(0, 0);
    model_reset();
    #2;
    for (int a = 0; a < DEP; a++) begin
      set_rd(a, DEP - 1 - a);
      #1;
      chk("rst_rd_a", rd_data_a[0 +: DW], '0);
      chk("rst_rd_b", rd_data_b[DW +: DW], '0);
    end
    chk("rst_busy", {31'b0, busy_a}, '0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // write then read back on every port
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; wr0_be = 4'hF; set_rd(5, 5);
    cyc("wr5");
    idle_inputs(); #1;
    chk("rd5_p0", rd_data_b[0 +: DW], 32'hDEADBEEF);
    chk("rd5_p1", rd_data_b[DW +: DW], 32'hDEADBEEF);
    chk("rd5_a1", rd_data_a[DW +: DW], 32'hDEADBEEF);

    // byte enables with same-address collision
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11223344; wr0_be = 4'hF; set_rd(7, 3);
    cyc("wr7");
    wr0_data = 32'hAAAAAAAA; wr0_be = 4'h3;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'hBBBBBBBB; wr1_be = 4'h6;
    #1;
    chk("coll_byp", rd_data_a[0 +: DW], 32'h11BBBBAA);
    cyc("coll");
    idle_inputs(); #1;
    chk("coll_a", rd_data_a[0 +: DW], 32'h11BBBBAA);
    chk("coll_b", rd_data_b[0 +: DW], 32'h11BBBBAA);

    // bypass versus no bypass
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h12345678; wr0_be = 4'hF; set_rd(9, 9);
    #1;
    chk("byp_same", rd_data_a[0 +: DW], 32'h12345678);
    chk("nobyp_old", rd_data_b[0 +: DW], 32'h0);
    cyc("byp");
    idle_inputs(); #1;
    chk("nobyp_new", rd_data_b[0 +: DW], 32'h12345678);

    // zero register
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF; wr0_be = 4'hF; set_rd(0, 0);
    #1;
    chk("zero_byp", rd_data_a[0 +: DW], 32'h0);
    cyc("zero");
    idle_inputs(); #1;
    chk("zero_a", rd_data_a[0 +: DW], 32'h0);
    chk("zero_b", rd_data_b[0 +: DW], 32'hFFFFFFFF);

    // fill with index+1, then sweep with a write dropped mid-sweep
    for (int i = 0; i < DEP; i++) begin
      wr0_en = 1; wr0_addr = AW'(i); wr0_data = DW'(i + 1); wr0_be = 4'hF;
      set_rd($urandom_range(0, DEP - 1), i);
      cyc("fill");
    end
    idle_inputs();
    clr_start = 1;
    cyc("clr_go");
    clr_start = 0;
    n = 0;
    while (busy_a && n < 100) begin
      idle_inputs();
      if (n == 5) begin wr0_en = 1; wr0_addr = 3; wr0_data = 32'hCAFEF00D; wr0_be = 4'hF; end
      set_rd($urandom_range(0, DEP - 1), 3);
      cyc("sweep");
      n++;
    end
    chk("sweep_len", DW'(n), DW'(DEP));
    idle_inputs();
    for (int i = 0; i < DEP; i += 2) begin
      set_rd(i, i + 1);
      cyc("post_clr");
    end
    set_rd(3, 31); #1;
    chk("r3_clr", rd_data_b[0 +: DW], 32'h0);
    chk("r31_clr", rd_data_b[DW +: DW], 32'h0);

    // reset mid-sweep
    for (int i = 0; i < 8; i++) begin
      wr0_en = 1; wr0_addr = AW'($urandom_range(1, DEP - 1)); wr0_data = $urandom; wr0_be = 4'hF;
      cyc("refill");
    end
    idle_inputs(); clr_start = 1;
    cyc("clr2_go");
    clr_start = 0;
    for (int i = 0; i < 10; i++) cyc("sweep2");
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_mid_busy", {31'b0, busy_a}, '0);
    for (int a = 0; a < DEP; a++) begin
      set_rd(a, a);
      #1;
      chk("rst_mid_b", rd_data_b[0 +: DW], '0);
    end
    @(negedge clk);
    rst_n = 1;
    wr0_en = 1; wr0_addr = 12; wr0_data = 32'h0BADC0DE; wr0_be = 4'hF; set_rd(12, 12);
    @(posedge clk); model_edge(); #1;
    idle_inputs(); #1;
    chk("first_wr", rd_data_b[0 +: DW], 32'h0BADC0DE);

    // randomized traffic against the reference
    for (int t = 0; t < 3000; t++) begin
      wr0_en   = ($urandom_range(0, 9) < 7);
      wr0_addr = AW'($urandom_range(0, DEP - 1));
      wr0_data = $urandom;
      wr0_be   = 4'($urandom_range(0, 15));
      wr1_en   = ($urandom_range(0, 9) < 7);
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, DEP - 1));
      wr1_data = $urandom;
      wr1_be   = 4'($urandom_range(0, 15));
      clr_start = ($urandom_range(0, 149) == 0);
      set_rd(($urandom_range(0, 1) == 0) ? int'(wr0_addr) : $urandom_range(0, DEP - 1),
             ($urandom_range(0, 1) == 0) ? int'(wr1_addr) : $urandom_range(0, DEP - 1));
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
